// File: rtl/mem_bus_arbiter_if.sv
// Cache-side request/response bundle and the single RAM port shared by two CPUs.
// The master side drives requests and RAM responses; the arbiter uses the slave side.
interface mem_bus_arbiter_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0][31:0]  iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0][31:0]  iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS-1:0][31:0]  daddr;
    logic [CPUS-1:0][31:0]  dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS-1:0][31:0]  dload;
    logic [CPUS-1:0]        cctrans;
    logic [CPUS-1:0]        ccwait;
    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload;
    logic [1:0]             ramstate;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-CPU RAM arbiter: dcache beats icache, round-robin within each class.
// Define ARB_BLOCK_LOCK_EN to hold a dcache grant across words while cctrans is raised.
module mem_bus_arbiter #(
    parameter int CPUS = 2
) (
    input logic              CLK,
    input logic              RST,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
    localparam logic [1:0] ACCESS = 2'd2;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            dlast_q, dlast_d;
    logic            ilast_q, ilast_d;
    logic            lock_q, lock_d;
    logic            done;
    logic            hold;
    logic            rel_ok;
    logic [CPUS-1:0] dreq;

    assign done = (bus.ramstate == ACCESS);
    assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_BLOCK_LOCK_EN
    assign hold   = lock_q | bus.cctrans[gnt_q];
    assign rel_ok = ~bus.cctrans[gnt_q] & (~dreq[gnt_q] | done);
`else
    logic cctrans_unused;
    assign cctrans_unused = ^bus.cctrans;
    assign hold   = 1'b0;
    assign rel_ok = 1'b0;
`endif

    // With both CPUs requesting, the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            dlast_q <= 1'b1;
            ilast_q <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            dlast_q <= dlast_d;
            ilast_q <= ilast_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        dlast_d = dlast_q;
        ilast_d = ilast_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (|dreq) begin
                    state_d = DGRANT;
                    gnt_d   = rr_pick(dreq, dlast_q);
                end else if (|bus.iREN) begin
                    state_d = IGRANT;
                    gnt_d   = rr_pick(bus.iREN, ilast_q);
                end
            end
            DGRANT: begin
                if (hold) begin
                    if (rel_ok) begin
                        state_d = IDLE;
                        lock_d  = 1'b0;
                        dlast_d = gnt_q;
                    end else begin
                        lock_d  = 1'b1;
                    end
                end else if (done) begin
                    state_d = IDLE;
                    dlast_d = gnt_q;
                end else if (!dreq[gnt_q]) begin
                    // Abandoned before ACCESS: no word served, pointer untouched.
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (done) begin
                    state_d = IDLE;
                    ilast_d = gnt_q;
                end else if (!bus.iREN[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ccwait   = '0;
        case (state_q)
            DGRANT: begin
                // Write wins when both enables are raised.
                bus.ramWEN         = bus.dWEN[gnt_q];
                bus.ramREN         = bus.dREN[gnt_q] & ~bus.dWEN[gnt_q];
                bus.ramaddr        = bus.daddr[gnt_q];
                bus.ramstore       = bus.dstore[gnt_q];
                bus.dwait[gnt_q]   = ~done;
                bus.dload[gnt_q]   = bus.ramload;
                bus.ccwait[~gnt_q] = 1'b1;
            end
            IGRANT: begin
                bus.ramREN       = bus.iREN[gnt_q];
                bus.ramaddr      = bus.iaddr[gnt_q];
                bus.iwait[gnt_q] = ~done;
                bus.iload[gnt_q] = bus.ramload;
            end
            default: ;
        endcase
    end
endmodule
